alu_op_sequencer: RTL and testbench

Command sequencer sitting directly upstream of the ALU core. It drives the ALU's `calculate`/`opcode`/`opA`/`opB` inputs and consumes its `coreOut`/`opComplete` outputs. It buffers operation requests in a small command FIFO, issues them to the ALU one at a time and holds operands stable until completion. Each result is returned on a valid/ready output port, tagged with its opcode and an error flag that is set on timeout.

---
 rtl/alu_op_sequencer.sv | 126 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers ALU commands in a FIFO, issues them one at a time, returns tagged results.
//   pulse/resetN                  clock, async active-low reset
//   cmdValid/cmdReady/cmdOpcode/cmdA/cmdB   command push port
//   aluCalculate/aluOpcode/aluOpA/aluOpB    drive to ALU core
//   aluResult/aluComplete                   from ALU core
//   resValid/resReady/resData/resOpcode/resErr  result port (resErr = timeout)
//   busy                          FIFO non-empty or FSM not idle
module alu_op_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        pulse,
    input  logic        resetN,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic [3:0]  cmdOpcode,
    input  logic [7:0]  cmdA,
    input  logic [7:0]  cmdB,
    output logic        aluCalculate,
    output logic [3:0]  aluOpcode,
    output logic [7:0]  aluOpA,
    output logic [7:0]  aluOpB,
    input  logic [15:0] aluResult,
    input  logic        aluComplete,
    output logic        resValid,
    input  logic        resReady,
    output logic [15:0] resData,
    output logic [3:0]  resOpcode,
    output logic        resErr,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, OUTPUT} state_t;

    state_t          state_q, state_d;
    logic [19:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     count_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      op_q, op_d, rop_q, rop_d;
    logic [7:0]      a_q, a_d, b_q, b_d;
    logic [15:0]     data_q, data_d;
    logic            err_q, err_d;
    logic            push, pop;

    assign cmdReady     = count_q < FULL;
    assign push         = cmdValid && cmdReady;
    assign aluCalculate = state_q == ISSUE;
    assign resValid     = state_q == OUTPUT;
    assign busy         = (state_q != IDLE) || (count_q != '0);
    assign aluOpcode    = op_q;
    assign aluOpA       = a_q;
    assign aluOpB       = b_q;
    assign resData      = data_q;
    assign resOpcode    = rop_q;
    assign resErr       = err_q;

    always_ff @(posedge pulse) begin
        if (push) mem_q[wr_q] <= {cmdOpcode, cmdA, cmdB};
    end

    // A still-high aluComplete from the previous op blocks the next issue.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        rop_d   = rop_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (count_q != '0 && !aluComplete) begin
                pop              = 1'b1;
                {op_d, a_d, b_d} = mem_q[rd_q];
                cnt_d            = '0;
                state_d          = ISSUE;
            end
            ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                // completion on the timeout cycle wins over the timeout
                if (aluComplete || cnt_q == LAST) begin
                    data_d  = aluComplete ? aluResult : 16'hFFFF;
                    rop_d   = op_q;
                    err_d   = !aluComplete;
                    state_d = OUTPUT;
                end
            end
            OUTPUT: state_d = resReady ? IDLE : OUTPUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pulse or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            rop_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_q + AW'(push);
            rd_q    <= rd_q + AW'(pop);
            count_q <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            rop_q   <= rop_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized and directed checks of alu_op_sequencer against a stub ALU and result model.
module tb_alu_op_sequencer;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        pulse = 1'b0;
    logic        resetN = 1'b0;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic [3:0]  cmdOpcode = '0;
    logic [7:0]  cmdA = '0;
    logic [7:0]  cmdB = '0;
    logic        aluCalculate;
    logic [3:0]  aluOpcode;
    logic [7:0]  aluOpA;
    logic [7:0]  aluOpB;
    logic [15:0] aluResult;
    logic        aluComplete;
    logic        resValid;
    logic        resReady = 1'b0;
    logic [15:0] resData;
    logic [3:0]  resOpcode;
    logic        resErr;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int lat = 3;
    int sticky = 0;

    alu_op_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .pulse(pulse), .resetN(resetN),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOpcode(cmdOpcode), .cmdA(cmdA), .cmdB(cmdB),
        .aluCalculate(aluCalculate), .aluOpcode(aluOpcode), .aluOpA(aluOpA), .aluOpB(aluOpB),
        .aluResult(aluResult), .aluComplete(aluComplete),
        .resValid(resValid), .resReady(resReady), .resData(resData), .resOpcode(resOpcode),
        .resErr(resErr), .busy(busy)
    );

    always #5 pulse = ~pulse;

    // stub ALU: complete is seen at the edge where calculate has been high for cur_lat cycles,
    // then lingers for `sticky` extra cycles after calculate falls
    int   hc, hold, cur_lat;
    logic comp;
    assign aluResult   = {aluOpA, aluOpB};
    assign aluComplete = comp;

    always @(posedge pulse or negedge resetN) begin
        if (!resetN) begin
            hc <= 0; hold <= 0; comp <= 1'b0; cur_lat <= lat;
        end else if (aluCalculate) begin
            hc <= hc + 1;
            if (hc + 2 >= cur_lat) comp <= 1'b1;
            hold <= sticky;
        end else begin
            hc <= 0;
            cur_lat <= lat;
            if (hold > 0) hold <= hold - 1;
            else comp <= 1'b0;
        end
    end

    // observation + reference model: accepted commands are issued in order; each result is
    // {a,b} if the stub latency fits within TIMEOUT, else an error result after TIMEOUT cycles
    logic [20:0] got_q[$], exp_q[$];
    logic [19:0] acc_q[$];
    int runs_q[$], exp_runs_q[$], gaps_q[$];
    int stab_err, overlap_err, acc_n, run, low, cyc, acc_cyc, rise_cyc, clr_req, clr_ack;
    logic calc_prev;
    logic [19:0] held, c;

    always @(negedge pulse) begin
        cyc++;
        if (!resetN || clr_req != clr_ack) begin
            got_q.delete(); exp_q.delete(); acc_q.delete();
            runs_q.delete(); exp_runs_q.delete(); gaps_q.delete();
            stab_err = 0; overlap_err = 0; acc_n = 0; run = 0; low = 0;
            clr_ack = clr_req;
            if (!resetN) calc_prev = 1'b0;
        end else begin
            if (cmdValid && cmdReady) begin
                acc_q.push_back({cmdOpcode, cmdA, cmdB});
                acc_n++;
                acc_cyc = cyc;
            end
            if (aluCalculate && !calc_prev) begin
                rise_cyc = cyc;
                gaps_q.push_back(low);
                low = 0;
                run = 0;
                held = {aluOpcode, aluOpA, aluOpB};
                if (aluComplete) overlap_err++;
                if (acc_q.size() > 0) begin
                    c = acc_q.pop_front();
                    exp_q.push_back(cur_lat > TIMEOUT ? {1'b1, c[19:16], 16'hFFFF} : {1'b0, c});
                    exp_runs_q.push_back(cur_lat > TIMEOUT ? TIMEOUT : cur_lat);
                end else overlap_err++;
            end
            if (aluCalculate) begin
                run++;
                if ({aluOpcode, aluOpA, aluOpB} !== held) stab_err++;
            end else begin
                if (calc_prev) runs_q.push_back(run);
                low++;
            end
            if (resValid && resReady) got_q.push_back({resErr, resOpcode, resData});
            calc_prev = aluCalculate;
        end
    end

    task automatic step();
        @(posedge pulse);
        #1;
    endtask

    task automatic clear();
        clr_req++;
        @(negedge pulse);
        step();
    endtask

    task automatic push_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        cmdValid = 1'b1; cmdOpcode = op; cmdA = a; cmdB = b;
        step();
        cmdValid = 1'b0;
    endtask

    task automatic drain(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (got_q.size() >= n && !busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (3) step();
        checks++;
        if ({aluCalculate, resValid, resErr, busy} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {aluCalculate, resValid, resErr, busy});
        end
        checks++;
        if ({aluOpcode, aluOpA, aluOpB} !== 20'h0) begin
            errors++; $display("FAIL reset_alu_regs: got %h expected 00000", {aluOpcode, aluOpA, aluOpB});
        end
        checks++;
        if ({resOpcode, resData} !== 20'h0) begin
            errors++; $display("FAIL reset_res_regs: got %h expected 00000", {resOpcode, resData});
        end
        checks++;
        if (cmdReady !== 1'b1) begin
            errors++; $display("FAIL reset_cmdReady: got %b expected 1", cmdReady);
        end
        resetN = 1'b1;
        step();
        clear();
    endtask

    task automatic test_single();
        bit ok;
        clear();
        lat = 3; resReady = 1'b1;
        push_cmd(4'd0, 8'd127, 8'd126);
        drain(1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_drain: got timeout expected completion"); end
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL single_count: got %0d expected 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {1'b0, 4'd0, 16'h7F7E}) begin
                errors++; $display("FAIL single_result: got %h expected %h", got_q[0], {1'b0, 4'd0, 16'h7F7E});
            end
        end
        checks++;
        if (runs_q.size() != 1 || runs_q[0] != 3) begin
            errors++; $display("FAIL single_calc_len: got %0d expected 3", runs_q.size() ? runs_q[0] : -1);
        end
        checks++;
        if (rise_cyc - acc_cyc != 2) begin
            errors++; $display("FAIL single_issue_latency: got %0d expected 2", rise_cyc - acc_cyc);
        end
        checks++;
        if (stab_err != 0) begin
            errors++; $display("FAIL single_operand_stable: got %0d expected 0", stab_err);
        end
    endtask

    task automatic test_fill();
        bit ok;
        logic [20:0] e;
        clear();
        lat = 3; resReady = 1'b0;
        for (int i = 1; i <= 5; i++) push_cmd(4'(i), 8'(8'h10 + i), 8'(8'hA0 + i));
        checks++;
        if (cmdReady !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL fill_full: got ready=%b busy=%b expected ready=0 busy=1", cmdReady, busy);
        end
        cmdValid = 1'b1; cmdOpcode = 4'd6; cmdA = 8'h66; cmdB = 8'h66;
        repeat (3) step();
        cmdValid = 1'b0;
        checks++;
        if (acc_n != 5 || cmdReady !== 1'b0) begin
            errors++; $display("FAIL fill_ignore_sixth: got accepted=%0d ready=%b expected 5 0", acc_n, cmdReady);
        end
        checks++;
        if (resValid !== 1'b1 || resOpcode !== 4'd1 || resData !== 16'h11A1) begin
            errors++; $display("FAIL fill_hold: got v=%b op=%h d=%h expected 1 1 11a1", resValid, resOpcode, resData);
        end
        resReady = 1'b1;
        drain(5, ok);
        checks++;
        if (!ok || got_q.size() != 5) begin
            errors++; $display("FAIL fill_drain: got %0d results expected 5", got_q.size());
        end else for (int i = 0; i < 5; i++) begin
            e = {1'b0, 4'(i + 1), 8'(8'h11 + i), 8'(8'hA1 + i)};
            checks++;
            if (got_q[i] !== e) begin
                errors++; $display("FAIL fill_result%0d: got %h expected %h", i, got_q[i], e);
            end
        end
        for (int i = 2; i < 5 && i < gaps_q.size(); i++) begin
            checks++;
            if (gaps_q[i] != 2) begin
                errors++; $display("FAIL fill_issue_gap%0d: got %0d expected 2", i, gaps_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int w;
        clear();
        lat = 100; resReady = 1'b0;
        push_cmd(4'd6, 8'h01, 8'h02);
        push_cmd(4'd7, 8'h03, 8'h04);
        w = 0;
        while (!resValid && w < 60) begin step(); w++; end
        checks++;
        if (resValid !== 1'b1 || resErr !== 1'b1 || resData !== 16'hFFFF || resOpcode !== 4'd6) begin
            errors++; $display("FAIL timeout_result: got v=%b e=%b d=%h op=%h expected 1 1 ffff 6",
                               resValid, resErr, resData, resOpcode);
        end
        lat = 3; resReady = 1'b1;
        drain(2, ok);
        checks++;
        if (!ok || got_q.size() != 2 || runs_q.size() != 2) begin
            errors++; $display("FAIL timeout_drain: got %0d results expected 2", got_q.size());
        end else begin
            checks++;
            if (got_q[1] !== {1'b0, 4'd7, 16'h0304}) begin
                errors++; $display("FAIL timeout_next: got %h expected %h", got_q[1], {1'b0, 4'd7, 16'h0304});
            end
            checks++;
            if (runs_q[0] != TIMEOUT || runs_q[1] != 3) begin
                errors++; $display("FAIL timeout_calc_len: got %0d,%0d expected 8,3", runs_q[0], runs_q[1]);
            end
        end
        clear();
        lat = TIMEOUT;
        push_cmd(4'd8, 8'hAB, 8'hCD);
        drain(1, ok);
        lat = TIMEOUT + 1;
        push_cmd(4'd9, 8'h12, 8'h34);
        drain(2, ok);
        checks++;
        if (!ok || got_q.size() != 2) begin
            errors++; $display("FAIL boundary_drain: got %0d results expected 2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {1'b0, 4'd8, 16'hABCD}) begin
                errors++; $display("FAIL boundary_success: got %h expected %h", got_q[0], {1'b0, 4'd8, 16'hABCD});
            end
            checks++;
            if (got_q[1] !== {1'b1, 4'd9, 16'hFFFF}) begin
                errors++; $display("FAIL boundary_timeout: got %h expected %h", got_q[1], {1'b1, 4'd9, 16'hFFFF});
            end
        end
        lat = 3;
    endtask

    task automatic test_sticky();
        bit ok;
        clear();
        lat = 3; sticky = 2; resReady = 1'b1;
        for (int i = 0; i < 3; i++) push_cmd(4'(i + 10), 8'(i), 8'(i + 100));
        drain(3, ok);
        sticky = 0;
        checks++;
        if (!ok || got_q.size() != 3 || gaps_q.size() != 3) begin
            errors++; $display("FAIL sticky_drain: got %0d results expected 3", got_q.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (gaps_q[i] != 4) begin
                    errors++; $display("FAIL sticky_gap%0d: got %0d expected 4", i, gaps_q[i]);
                end
            end
            checks++;
            if (got_q[2] !== {1'b0, 4'd12, 16'h0266}) begin
                errors++; $display("FAIL sticky_result: got %h expected %h", got_q[2], {1'b0, 4'd12, 16'h0266});
            end
        end
        checks++;
        if (overlap_err != 0) begin
            errors++; $display("FAIL sticky_overlap: got %0d expected 0", overlap_err);
        end
        repeat (4) step();
    endtask

    task automatic test_reset_mid_issue();
        clear();
        lat = 100; resReady = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(4'(i + 9), 8'(i), 8'(i));
        step();
        #3 resetN = 1'b0;
        #1;
        checks++;
        if ({aluCalculate, busy, cmdReady, resValid} !== 4'b0010) begin
            errors++; $display("FAIL midreset_outputs: got %b expected 0010", {aluCalculate, busy, cmdReady, resValid});
        end
        step();
        resetN = 1'b1;
        lat = 3;
        repeat (30) step();
        checks++;
        if (got_q.size() != 0 || gaps_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_after: got results=%0d issues=%0d busy=%b expected 0 0 0",
                               got_q.size(), gaps_q.size(), busy);
        end
    endtask

    task automatic test_random();
        bit ok;
        clear();
        for (int i = 0; i < 600; i++) begin
            cmdValid  = 1'($urandom_range(0, 1));
            cmdOpcode = 4'($urandom);
            cmdA      = 8'($urandom);
            cmdB      = 8'($urandom);
            resReady  = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 5) == 0) lat = $urandom_range(2, 10);
            step();
        end
        cmdValid = 1'b0; resReady = 1'b1;
        drain(0, ok);
        checks++;
        if (!ok || acc_q.size() != 0 || got_q.size() != exp_q.size() || got_q.size() == 0) begin
            errors++; $display("FAIL random_count: got %0d results expected %0d (pending %0d)",
                               got_q.size(), exp_q.size(), acc_q.size());
        end else for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || runs_q[i] != exp_runs_q[i]) begin
                errors++; $display("FAIL random_result%0d: got %h len %0d expected %h len %0d",
                                   i, got_q[i], runs_q[i], exp_q[i], exp_runs_q[i]);
            end
        end
        checks++;
        if (stab_err != 0 || overlap_err != 0) begin
            errors++; $display("FAIL random_stability: got stab=%0d overlap=%0d expected 0 0", stab_err, overlap_err);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_timeout();
        test_sticky();
        test_reset_mid_issue();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
